// File: rtl/sdcard_init_seq_if.sv
// Bus between the SD initialisation sequencer (master) and the SD
// command-line controller (slave): clock divider, command issue and
// response signals.
interface sdcard_init_seq_if;
    logic [15:0] clkdiv;
    logic        cc_start;
    logic [15:0] cc_precnt;
    logic [5:0]  cc_cmd;
    logic [31:0] cc_arg;
    logic        cc_busy;
    logic        cc_done;
    logic        cc_timeout;
    logic        cc_syntaxe;
    logic [31:0] cc_resparg;

    modport master (output clkdiv, cc_start, cc_precnt, cc_cmd, cc_arg,
                    input  cc_busy, cc_done, cc_timeout, cc_syntaxe, cc_resparg);
    modport slave  (input  clkdiv, cc_start, cc_precnt, cc_cmd, cc_arg,
                    output cc_busy, cc_done, cc_timeout, cc_syntaxe, cc_resparg);
endinterface

// File: rtl/sdcard_init_seq.sv
// SD-mode card identification/initialisation sequencer:
// CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7, then transfer clock.
module sdcard_init_seq #(
    parameter logic [15:0] CLKDIV_SLOW  = 16'd123,
    parameter logic [15:0] CLKDIV_FAST  = 16'd1,
    parameter logic [15:0] PRECNT_INIT  = 16'd128,
    parameter logic [15:0] PRECNT_CMD   = 16'd16,
    parameter logic [15:0] ACMD41_TRIES = 16'd4000,
    parameter logic [3:0]  CMD_TRIES    = 4'd3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              init_start,
    output logic              ready,
    output logic              error,
    output logic [1:0]        card_type,
    output logic [15:0]       rca,
    output logic [5:0]        err_cmd,
    sdcard_init_seq_if.master cc
);

    // The command being worked on (step) is kept apart from the
    // issue/wait/evaluate phase so every command shares one handshake.
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, READY, ERROR} state_t;
    typedef enum logic [2:0] {S_CMD0, S_CMD8, S_CMD55, S_ACMD41,
                              S_CMD2, S_CMD3, S_CMD7} step_t;

    state_t      state, state_nxt;
    step_t       step, step_nxt;
    logic [15:0] acmd_cnt, acmd_cnt_nxt;
    logic [3:0]  try_cnt, try_cnt_nxt;
    logic        rsp_to, rsp_to_nxt, rsp_se, rsp_se_nxt;
    logic [15:0] rsp_hi, rsp_hi_nxt;
    logic [11:0] rsp_lo, rsp_lo_nxt;
    logic        ready_nxt, error_nxt;
    logic [1:0]  card_type_nxt;
    logic [15:0] rca_nxt;
    logic [5:0]  err_cmd_nxt;
    logic [15:0] clkdiv_nxt, cc_precnt_nxt;
    logic        cc_start_nxt;
    logic [5:0]  cc_cmd_nxt;
    logic [31:0] cc_arg_nxt;

    logic        step_pass, acmd_last, try_last;
    logic [5:0]  step_idx;

    assign acmd_last = (acmd_cnt <= 16'd1);
    assign try_last  = (try_cnt <= 4'd1);

    // Command index of the current step and whether its response passed.
    always_comb begin
        case (step)
            S_CMD0:   step_idx = 6'd0;
            S_CMD8:   step_idx = 6'd8;
            S_CMD55:  step_idx = 6'd55;
            S_ACMD41: step_idx = 6'd41;
            S_CMD2:   step_idx = 6'd2;
            S_CMD3:   step_idx = 6'd3;
            default:  step_idx = 6'd7;
        endcase
        case (step)
            S_CMD0:   step_pass = 1'b1;
            S_CMD8:   step_pass = rsp_to | (~rsp_se & (rsp_lo == 12'h1AA));
            S_ACMD41: step_pass = ~rsp_to & rsp_hi[15];
            S_CMD3:   step_pass = ~rsp_to & ~rsp_se & (rsp_hi != 16'h0);
            default:  step_pass = ~rsp_to & ~rsp_se;
        endcase
    end

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            step         <= S_CMD0;
            acmd_cnt     <= '0;
            try_cnt      <= '0;
            rsp_to       <= 1'b0;
            rsp_se       <= 1'b0;
            rsp_hi       <= '0;
            rsp_lo       <= '0;
            ready        <= 1'b0;
            error        <= 1'b0;
            card_type    <= '0;
            rca          <= '0;
            err_cmd      <= '0;
            cc.clkdiv    <= CLKDIV_SLOW;
            cc.cc_start  <= 1'b0;
            cc.cc_precnt <= '0;
            cc.cc_cmd    <= '0;
            cc.cc_arg    <= '0;
        end else begin
            state        <= state_nxt;
            step         <= step_nxt;
            acmd_cnt     <= acmd_cnt_nxt;
            try_cnt      <= try_cnt_nxt;
            rsp_to       <= rsp_to_nxt;
            rsp_se       <= rsp_se_nxt;
            rsp_hi       <= rsp_hi_nxt;
            rsp_lo       <= rsp_lo_nxt;
            ready        <= ready_nxt;
            error        <= error_nxt;
            card_type    <= card_type_nxt;
            rca          <= rca_nxt;
            err_cmd      <= err_cmd_nxt;
            cc.clkdiv    <= clkdiv_nxt;
            cc.cc_start  <= cc_start_nxt;
            cc.cc_precnt <= cc_precnt_nxt;
            cc.cc_cmd    <= cc_cmd_nxt;
            cc.cc_arg    <= cc_arg_nxt;
        end
    end

    // Next phase and next command step.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE, READY, ERROR: begin
                if (init_start) begin
                    state_nxt = ISSUE;
                    step_nxt  = S_CMD0;
                end
            end
            ISSUE: if (!cc.cc_busy) state_nxt = WAIT;
            WAIT:  if (cc.cc_done) state_nxt = EVAL;
            EVAL: begin
                state_nxt = ISSUE;
                if (step_pass) begin
                    case (step)
                        S_CMD0:   step_nxt = S_CMD8;
                        S_CMD8:   step_nxt = S_CMD55;
                        S_CMD55:  step_nxt = S_ACMD41;
                        S_ACMD41: step_nxt = S_CMD2;
                        S_CMD2:   step_nxt = S_CMD3;
                        S_CMD3:   step_nxt = S_CMD7;
                        default:  state_nxt = READY;
                    endcase
                end else begin
                    case (step)
                        S_CMD55, S_ACMD41: begin
                            step_nxt = S_CMD55;
                            if (acmd_last) state_nxt = ERROR;
                        end
                        S_CMD2, S_CMD3, S_CMD7: if (try_last) state_nxt = ERROR;
                        default: state_nxt = ERROR;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath and controller-facing registers.
    always_comb begin
        acmd_cnt_nxt  = acmd_cnt;
        try_cnt_nxt   = try_cnt;
        rsp_to_nxt    = rsp_to;
        rsp_se_nxt    = rsp_se;
        rsp_hi_nxt    = rsp_hi;
        rsp_lo_nxt    = rsp_lo;
        ready_nxt     = ready;
        error_nxt     = error;
        card_type_nxt = card_type;
        rca_nxt       = rca;
        err_cmd_nxt   = err_cmd;
        clkdiv_nxt    = cc.clkdiv;
        cc_start_nxt  = 1'b0;
        cc_precnt_nxt = cc.cc_precnt;
        cc_cmd_nxt    = cc.cc_cmd;
        cc_arg_nxt    = cc.cc_arg;
        case (state)
            IDLE, READY, ERROR: begin
                if (init_start) begin
                    ready_nxt     = 1'b0;
                    error_nxt     = 1'b0;
                    card_type_nxt = '0;
                    rca_nxt       = '0;
                    err_cmd_nxt   = '0;
                    clkdiv_nxt    = CLKDIV_SLOW;
                    acmd_cnt_nxt  = ACMD41_TRIES;
                end
            end
            ISSUE: begin
                if (!cc.cc_busy) begin
                    cc_start_nxt  = 1'b1;
                    cc_cmd_nxt    = step_idx;
                    cc_precnt_nxt = (step == S_CMD0) ? PRECNT_INIT : PRECNT_CMD;
                    case (step)
                        S_CMD8:   cc_arg_nxt = 32'h0000_01AA;
                        S_ACMD41: cc_arg_nxt = (card_type == 2'd2) ? 32'h4010_0000
                                                                   : 32'h0010_0000;
                        S_CMD7:   cc_arg_nxt = {rca, 16'h0};
                        default:  cc_arg_nxt = '0;
                    endcase
                    if (step == S_CMD7) clkdiv_nxt = CLKDIV_FAST;
                end
            end
            WAIT: begin
                if (cc.cc_done) begin
                    rsp_to_nxt = cc.cc_timeout;
                    rsp_se_nxt = cc.cc_syntaxe;
                    rsp_hi_nxt = cc.cc_resparg[31:16];
                    rsp_lo_nxt = cc.cc_resparg[11:0];
                end
            end
            EVAL: begin
                if (step_pass) begin
                    case (step)
                        S_CMD8: card_type_nxt = rsp_to ? 2'd1 : 2'd2;
                        S_ACMD41: begin
                            if (card_type == 2'd2 && rsp_hi[14]) card_type_nxt = 2'd3;
                            try_cnt_nxt = CMD_TRIES;
                        end
                        S_CMD2: try_cnt_nxt = CMD_TRIES;
                        S_CMD3: begin
                            rca_nxt     = rsp_hi;
                            try_cnt_nxt = CMD_TRIES;
                        end
                        S_CMD7:  ready_nxt = 1'b1;
                        default: ;
                    endcase
                end else begin
                    case (step)
                        S_CMD55, S_ACMD41: begin
                            acmd_cnt_nxt = acmd_last ? '0 : acmd_cnt - 16'd1;
                            if (acmd_last) begin
                                error_nxt   = 1'b1;
                                err_cmd_nxt = 6'd41;
                                clkdiv_nxt  = CLKDIV_SLOW;
                            end
                        end
                        S_CMD2, S_CMD3, S_CMD7: begin
                            try_cnt_nxt = try_last ? '0 : try_cnt - 4'd1;
                            if (try_last) begin
                                error_nxt   = 1'b1;
                                err_cmd_nxt = step_idx;
                                clkdiv_nxt  = CLKDIV_SLOW;
                            end
                        end
                        default: begin
                            error_nxt   = 1'b1;
                            err_cmd_nxt = 6'd8;
                            clkdiv_nxt  = CLKDIV_SLOW;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdcard_init_seq.sv
// Bench for sdcard_init_seq: a card/command-controller model answers each
// command; the expected command stream is queued per scenario and checked
// as commands are issued; final outputs are checked from a vector table.
module tb_sdcard_init_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, init_a, init_b;
    logic ready_a, error_a, ready_b, error_b;
    logic [1:0]  type_a, type_b;
    logic [15:0] rca_a, rca_b;
    logic [5:0]  err_a, err_b;

    sdcard_init_seq_if ifa ();
    sdcard_init_seq_if ifb ();

    // A: default tries; B: short retry budgets for the exhaustion cases.
    sdcard_init_seq dut_a (
        .clk(clk), .rstn(rstn), .init_start(init_a), .ready(ready_a), .error(error_a),
        .card_type(type_a), .rca(rca_a), .err_cmd(err_a), .cc(ifa.master)
    );
    sdcard_init_seq #(.ACMD41_TRIES(16'd5), .CMD_TRIES(4'd2)) dut_b (
        .clk(clk), .rstn(rstn), .init_start(init_b), .ready(ready_b), .error(error_b),
        .card_type(type_b), .rca(rca_b), .err_cmd(err_b), .cc(ifb.master)
    );

    // Controller model drives whichever DUT is selected; the other sees an idle controller.
    bit          sel = 1'b0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_to = 1'b0, m_se = 1'b0;
    logic [31:0] m_arg = '0;

    assign ifa.cc_busy    = sel ? 1'b0 : m_busy;
    assign ifa.cc_done    = sel ? 1'b0 : m_done;
    assign ifa.cc_timeout = m_to;
    assign ifa.cc_syntaxe = m_se;
    assign ifa.cc_resparg = m_arg;
    assign ifb.cc_busy    = sel ? m_busy : 1'b0;
    assign ifb.cc_done    = sel ? m_done : 1'b0;
    assign ifb.cc_timeout = m_to;
    assign ifb.cc_syntaxe = m_se;
    assign ifb.cc_resparg = m_arg;

    logic        s_start, s_ready, s_error;
    logic [1:0]  s_type;
    logic [15:0] s_rca, s_clkdiv, s_precnt;
    logic [5:0]  s_err, s_cmd;
    logic [31:0] s_arg;
    assign s_start  = sel ? ifb.cc_start  : ifa.cc_start;
    assign s_cmd    = sel ? ifb.cc_cmd    : ifa.cc_cmd;
    assign s_arg    = sel ? ifb.cc_arg    : ifa.cc_arg;
    assign s_precnt = sel ? ifb.cc_precnt : ifa.cc_precnt;
    assign s_clkdiv = sel ? ifb.clkdiv    : ifa.clkdiv;
    assign s_ready  = sel ? ready_b : ready_a;
    assign s_error  = sel ? error_b : error_a;
    assign s_type   = sel ? type_b  : type_a;
    assign s_rca    = sel ? rca_b   : rca_a;
    assign s_err    = sel ? err_b   : err_a;

    typedef struct {
        bit          dut;
        bit          cmd8_to;
        logic [11:0] cmd8_echo;
        int          cmd55_fails;
        int          busy_polls;
        bit          ccs;
        int          rca_zero;
        logic [15:0] rca_val;
        bit          e_ready;
        bit          e_error;
        logic [1:0]  e_type;
        logic [15:0] e_rca;
        logic [5:0]  e_err;
        logic [15:0] e_clkdiv;
        int          e_n55;
    } vec_t;

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [15:0] precnt;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t m_e;
    vec_t cur;
    vec_t vecs[8];
    int   n_tests = 0, n_fail = 0;
    int   n55 = 0, n41 = 0, n3 = 0, viol = 0;
    int   lat = 0, tail = 0;
    logic        p_to, p_se;
    logic [31:0] p_arg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] c, input logic [31:0] a, input logic [15:0] p);
        cmd_t e;
        e.cmd = c; e.arg = a; e.precnt = p;
        exp_q.push_back(e);
    endtask

    // Expected command stream for a card behaviour, from the init sequence rules.
    task automatic build_expect(input vec_t v);
        int acmd_tries = v.dut ? 5 : 4000;
        int cmd_tries  = v.dut ? 2 : 3;
        int cnt   = acmd_tries;
        int f55   = v.cmd55_fails;
        int polls = 0;
        bit v2    = !v.cmd8_to;
        push(6'd0, 32'h0, 16'd128);
        push(6'd8, 32'h0000_01AA, 16'd16);
        if (!v.cmd8_to && v.cmd8_echo != 12'h1AA) return;
        while (1) begin
            push(6'd55, 32'h0, 16'd16);
            if (f55 > 0) begin
                f55--; cnt--;
                if (cnt == 0) return;
                continue;
            end
            push(6'd41, v2 ? 32'h4010_0000 : 32'h0010_0000, 16'd16);
            if (polls >= v.busy_polls) break;
            polls++; cnt--;
            if (cnt == 0) return;
        end
        push(6'd2, 32'h0, 16'd16);
        for (int k = 0; k < cmd_tries; k++) begin
            push(6'd3, 32'h0, 16'd16);
            if (k >= v.rca_zero) break;
            if (k == cmd_tries - 1) return;
        end
        push(6'd7, {v.rca_val, 16'h0}, 16'd16);
    endtask

    // Card + command-controller model; acts on the falling edge.
    always @(negedge clk) begin
        if (!rstn) begin
            m_busy = 1'b0; m_done = 1'b0; lat = 0; tail = 0;
        end else begin
            m_done = 1'b0;
            if (s_start) begin
                if (m_busy) viol++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_start: cmd %0d issued, none expected", s_cmd);
                end else begin
                    m_e = exp_q.pop_front();
                    check($sformatf("cmd_idx(exp %0d)", m_e.cmd), 32'(s_cmd), 32'(m_e.cmd));
                    check($sformatf("cmd%0d_arg", m_e.cmd), s_arg, m_e.arg);
                    check($sformatf("cmd%0d_precnt", m_e.cmd), 32'(s_precnt), 32'(m_e.precnt));
                end
                p_to = 1'b0; p_se = 1'b0; p_arg = '0;
                case (s_cmd)
                    6'd0: p_to = 1'b1;
                    6'd8: begin
                        p_to  = cur.cmd8_to;
                        p_arg = {20'h0, cur.cmd8_echo};
                    end
                    6'd55: begin
                        p_to  = (n55 < cur.cmd55_fails);
                        p_arg = 32'h0000_0120;
                        n55++;
                    end
                    6'd41: begin
                        p_se  = 1'b1;
                        p_arg = {(n41 >= cur.busy_polls), cur.ccs, 30'h00FF_8000};
                        n41++;
                    end
                    6'd3: begin
                        p_arg = {(n3 < cur.rca_zero) ? 16'h0 : cur.rca_val, 16'h0500};
                        n3++;
                    end
                    default: p_arg = $urandom;
                endcase
                m_busy = 1'b1;
                lat = $urandom_range(2, 5);
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    m_done = 1'b1; m_to = p_to; m_se = p_se; m_arg = p_arg;
                    tail = $urandom_range(0, 2);
                    if (tail == 0) m_busy = 1'b0;
                end
            end else if (tail > 0) begin
                tail--;
                if (tail == 0) m_busy = 1'b0;
            end
        end
    end

    task automatic pulse_init(input bit d);
        @(negedge clk);
        if (d) init_b = 1'b1; else init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0; init_b = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int c;
        cur = v; sel = v.dut; n55 = 0; n41 = 0; n3 = 0;
        build_expect(v);
        pulse_init(v.dut);
        check($sformatf("v%0d_start_clears", i), 32'({s_ready, s_error, s_type}), 32'h0);
        for (c = 0; c < 20000 && !(s_ready || s_error); c++) @(negedge clk);
        check($sformatf("v%0d_completes", i), 32'(s_ready | s_error), 32'h1);
        repeat (30) @(negedge clk);
        check($sformatf("v%0d_ready", i), 32'(s_ready), 32'(v.e_ready));
        check($sformatf("v%0d_error", i), 32'(s_error), 32'(v.e_error));
        check($sformatf("v%0d_card_type", i), 32'(s_type), 32'(v.e_type));
        check($sformatf("v%0d_rca", i), 32'(s_rca), 32'(v.e_rca));
        check($sformatf("v%0d_err_cmd", i), 32'(s_err), 32'(v.e_err));
        check($sformatf("v%0d_clkdiv", i), 32'(s_clkdiv), 32'(v.e_clkdiv));
        check($sformatf("v%0d_cmd55_count", i), n55, v.e_n55);
        check($sformatf("v%0d_cmds_left", i), exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int c;
        //          dut to  echo    f55 busy ccs rz  rca      rdy err typ e_rca    e_err clkdiv   n55
        vecs[0] = '{0, 0, 12'h1AA, 2,  3,   1,  0, 16'h1234, 1,  0,  3, 16'h1234, 0,  16'd1,   6};
        vecs[1] = '{0, 1, 12'h000, 0,  1,   1,  0, 16'hBEEF, 1,  0,  1, 16'hBEEF, 0,  16'd1,   2};
        vecs[2] = '{0, 0, 12'h1AA, 0,  0,   0,  0, 16'h0042, 1,  0,  2, 16'h0042, 0,  16'd1,   1};
        vecs[3] = '{0, 0, 12'h155, 0,  0,   1,  0, 16'h1111, 0,  1,  0, 16'h0000, 8,  16'd123, 0};
        vecs[4] = '{0, 0, 12'h1AA, 0,  0,   1,  2, 16'h0001, 1,  0,  3, 16'h0001, 0,  16'd1,   1};
        vecs[5] = '{1, 0, 12'h1AA, 0,  99,  1,  0, 16'h1111, 0,  1,  2, 16'h0000, 41, 16'd123, 5};
        vecs[6] = '{1, 0, 12'h1AA, 0,  0,   1,  2, 16'h0001, 0,  1,  3, 16'h0000, 3,  16'd123, 1};
        vecs[7] = '{1, 0, 12'h1AA, 5,  0,   1,  0, 16'h1111, 0,  1,  2, 16'h0000, 41, 16'd123, 5};

        rstn = 1'b0; init_a = 1'b0; init_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_a), 32'h0);
        check("rst_error", 32'(error_a), 32'h0);
        check("rst_type_rca_err", 32'({type_a, rca_a, err_a}), 32'h0);
        check("rst_clkdiv", 32'(ifa.clkdiv), 32'd123);
        check("rst_cc_start", 32'(ifa.cc_start), 32'h0);
        check("rst_cc_cmd_precnt", 32'({ifa.cc_cmd, ifa.cc_precnt}), 32'h0);
        check("rst_cc_arg", ifa.cc_arg, 32'h0);
        rstn = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset in the middle of the ACMD41 loop, with an ignored init_start first.
        cur = vecs[2]; cur.busy_polls = 50; cur.ccs = 1'b1;
        sel = 1'b0; n55 = 0; n41 = 0; n3 = 0;
        build_expect(cur);
        pulse_init(1'b0);
        for (c = 0; c < 5000 && n41 < 2; c++) @(negedge clk);
        pulse_init(1'b0);
        for (c = 0; c < 5000 && n41 < 4; c++) @(negedge clk);
        check("midreset_reached_loop", 32'(n41 >= 4), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("midreset_ready_error", 32'({ready_a, error_a}), 32'h0);
        check("midreset_type_rca_err", 32'({type_a, rca_a, err_a}), 32'h0);
        check("midreset_clkdiv", 32'(ifa.clkdiv), 32'd123);
        check("midreset_cc_regs", 32'({ifa.cc_start, ifa.cc_cmd, ifa.cc_precnt}), 32'h0);
        check("midreset_cc_arg", ifa.cc_arg, 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        run_vec(8, vecs[2]);

        check("start_while_busy", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
